// File: rtl/mine_neighbor_count.sv
// Mine neighbour counter: snapshots a mine map on start, then walks the
// board one cell per clock producing each cell's adjacent-mine count.
//
// Ports:
//   in_clka        - clock, all logic on the rising edge
//   in_reset       - synchronous active-high reset
//   in_start       - start request, only honoured while idle
//   in_mines       - mine map, bit i set -> mine in cell i
//   out_busy       - high while the board is being scanned
//   out_done       - one-cycle pulse when all results are valid
//   out_counts     - 4-bit neighbour count per cell, cell i at [4*i+3:4*i]
//   out_mine_total - number of mines in the snapshot map
module mine_neighbor_count #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int TOT_W = 5
) (
    input  logic                   in_clka,
    input  logic                   in_reset,
    input  logic                   in_start,
    input  logic [ROWS*COLS-1:0]   in_mines,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [4*ROWS*COLS-1:0] out_counts,
    output logic [TOT_W-1:0]       out_mine_total
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e                 state_q;
    logic [N-1:0]           snap_q;
    logic [IDX_W-1:0]       idx_q;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic [N-1:0][3:0]      counts_q;
    logic [TOT_W-1:0]       total_q;
    logic                   busy_q;
    logic                   done_q;

    logic [3:0]             nbr_d;
    logic [IDX_W-1:0]       nidx;
    int                     nr;
    int                     nc;

    // Row/column are tracked alongside idx so the neighbour window needs
    // no divider; cells off the board are simply skipped.
    always_comb begin
        nbr_d = '0;
        nidx  = '0;
        nr    = 0;
        nc    = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(row_q) + dr;
                nc = int'(col_q) + dc;
                if (!(dr == 0 && dc == 0) &&
                    nr >= 0 && nr < ROWS &&
                    nc >= 0 && nc < COLS) begin
                    nidx  = IDX_W'(nr * COLS + nc);
                    nbr_d = nbr_d + {3'b000, snap_q[nidx]};
                end
            end
        end
    end

    always_ff @(posedge in_clka) begin
        if (in_reset) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            counts_q <= '0;
            total_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (in_start) begin
                        snap_q   <= in_mines;
                        idx_q    <= '0;
                        row_q    <= '0;
                        col_q    <= '0;
                        counts_q <= '0;
                        total_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    counts_q[idx_q] <= nbr_d;
                    total_q <= total_q + TOT_W'(snap_q[idx_q]);
                    if (idx_q == IDX_W'(N - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_busy       = busy_q;
    assign out_done       = done_q;
    assign out_counts     = counts_q;
    assign out_mine_total = total_q;

endmodule
